// File: rtl/sump_pkg.sv
// Shared opcode map, controller state encoding and config-register select decode
// for the SUMP logic-analyzer controller.
package sump_pkg;

  localparam logic [7:0] OP_RESET     = 8'h00;
  localparam logic [7:0] OP_ARM       = 8'h01;
  localparam logic [7:0] OP_ID        = 8'h02;
  localparam logic [7:0] OP_META      = 8'h04;
  localparam logic [7:0] OP_DIV       = 8'h80;
  localparam logic [7:0] OP_CNT       = 8'h81;
  localparam logic [7:0] OP_FLAGS     = 8'h82;
  localparam logic [7:0] OP_TRIG_BASE = 8'hC0;
  localparam logic [7:0] OP_RISE      = 8'hD0;
  localparam logic [7:0] OP_FALL      = 8'hD1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_DECODE, ST_ID_WAIT, ST_META_START, ST_META_WAIT, ST_ARMED, ST_RUNNING
  } controller_state_t;

  typedef enum logic [3:0] {
    SEL_NONE, SEL_DIV, SEL_CNT, SEL_FLAGS, SEL_MASK, SEL_VALUE, SEL_CONFIG, SEL_RISE, SEL_FALL
  } cfg_sel_t;

  // Trigger opcodes 0xC0..0xCF carry the stage in bits [3:2] and the field in bits [1:0].
  function automatic cfg_sel_t decode_sel(input logic [7:0] op);
    cfg_sel_t sel;
    sel = SEL_NONE;
    if (op[7:4] == OP_TRIG_BASE[7:4]) begin
      case (op[1:0])
        2'd0:    sel = SEL_MASK;
        2'd1:    sel = SEL_VALUE;
        2'd2:    sel = SEL_CONFIG;
        default: sel = SEL_NONE;
      endcase
    end else begin
      case (op)
        OP_DIV:   sel = SEL_DIV;
        OP_CNT:   sel = SEL_CNT;
        OP_FLAGS: sel = SEL_FLAGS;
        OP_RISE:  sel = SEL_RISE;
        OP_FALL:  sel = SEL_FALL;
        default:  sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

  function automatic logic is_lifecycle(input logic [7:0] op);
    return (op == OP_ARM) || (op == OP_ID) || (op == OP_META);
  endfunction

endpackage

// File: rtl/sump_cfg_regs.sv
// Configuration register file: one decoded write per strobe, all outputs registered.
module sump_cfg_regs
  import sump_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int NUM_STAGES   = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               wr_en_i,
  input  cfg_sel_t                           sel_i,
  input  logic [1:0]                         stage_i,
  input  logic [31:0]                        data_i,
  output logic [23:0]                        divider_o,
  output logic [15:0]                        read_count_o,
  output logic [15:0]                        delay_count_o,
  output logic [31:0]                        flags_o,
  output logic [NUM_STAGES*SAMPLE_WIDTH-1:0] trig_mask_o,
  output logic [NUM_STAGES*SAMPLE_WIDTH-1:0] trig_value_o,
  output logic [NUM_STAGES*32-1:0]           trig_config_o,
  output logic [SAMPLE_WIDTH-1:0]            rise_pattern_o,
  output logic [SAMPLE_WIDTH-1:0]            fall_pattern_o
);

  logic stage_ok;
  assign stage_ok = int'(stage_i) < NUM_STAGES;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      divider_o      <= '0;
      read_count_o   <= '0;
      delay_count_o  <= '0;
      flags_o        <= '0;
      trig_mask_o    <= '0;
      trig_value_o   <= '0;
      trig_config_o  <= '0;
      rise_pattern_o <= '0;
      fall_pattern_o <= '0;
    end else if (wr_en_i) begin
      case (sel_i)
        SEL_DIV:   divider_o <= data_i[23:0];
        SEL_CNT: begin
          read_count_o  <= data_i[15:0];
          delay_count_o <= data_i[31:16];
        end
        SEL_FLAGS: flags_o <= data_i;
        // Stages beyond the configured count are silently dropped.
        SEL_MASK:   if (stage_ok) trig_mask_o[int'(stage_i)*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= data_i[SAMPLE_WIDTH-1:0];
        SEL_VALUE:  if (stage_ok) trig_value_o[int'(stage_i)*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= data_i[SAMPLE_WIDTH-1:0];
        SEL_CONFIG: if (stage_ok) trig_config_o[int'(stage_i)*32 +: 32] <= data_i;
        SEL_RISE:  rise_pattern_o <= data_i[SAMPLE_WIDTH-1:0];
        SEL_FALL:  fall_pattern_o <= data_i[SAMPLE_WIDTH-1:0];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sump_controller.sv
// SUMP command sequencer: decodes opcodes into the config register file, drives
// ID/metadata replies and tracks the arm/run/capture lifecycle.
module sump_controller
  import sump_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int NUM_STAGES   = 4
) (
  input  logic                               clock,
  input  logic                               ext_reset_n,
  input  logic [7:0]                         opcode,
  input  logic [31:0]                        command,
  input  logic                               cmd_recv_rx,
  input  logic                               run,
  input  logic                               capture_done,
  input  logic                               transmit_busy,
  input  logic                               meta_transmit_finish,
  output logic                               reset,
  output logic                               arm,
  output logic                               send_id,
  output logic                               begin_meta_transmit,
  output logic                               data_meta_mux,
  output logic                               armed,
  output logic                               cmd_dropped,
  output logic [23:0]                        divider,
  output logic [15:0]                        read_count,
  output logic [15:0]                        delay_count,
  output logic [31:0]                        flags,
  output logic [NUM_STAGES*SAMPLE_WIDTH-1:0] trig_mask,
  output logic [NUM_STAGES*SAMPLE_WIDTH-1:0] trig_value,
  output logic [NUM_STAGES*32-1:0]           trig_config,
  output logic [SAMPLE_WIDTH-1:0]            risePattern,
  output logic [SAMPLE_WIDTH-1:0]            fallPattern
);

  controller_state_t state_q;
  logic [7:0]  op_q;
  logic [31:0] cmd_q;
  logic id_pending_q, live_pend_q;
  logic reset_q, arm_q, send_id_q, begin_meta_q, mux_q, armed_q, dropped_q;
  cfg_sel_t sel;
  logic wr_en, abort;

  // A command taken while ARMED/RUNNING is acted on one cycle later (live_pend_q),
  // so it lands on the same cycle-2 timing as one decoded from IDLE.
  assign sel   = decode_sel(op_q);
  assign wr_en = ((state_q == ST_DECODE) || live_pend_q) && (sel != SEL_NONE);
  assign abort = live_pend_q && (op_q == OP_RESET);

  always_ff @(posedge clock) begin
    if (!ext_reset_n) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      cmd_q        <= '0;
      id_pending_q <= 1'b0;
      live_pend_q  <= 1'b0;
      reset_q      <= 1'b0;
      arm_q        <= 1'b0;
      send_id_q    <= 1'b0;
      begin_meta_q <= 1'b0;
      mux_q        <= 1'b0;
      armed_q      <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      reset_q      <= 1'b0;
      arm_q        <= 1'b0;
      send_id_q    <= 1'b0;
      begin_meta_q <= 1'b0;
      dropped_q    <= 1'b0;
      live_pend_q  <= 1'b0;
      case (state_q)
        ST_IDLE: if (cmd_recv_rx) begin
          op_q    <= opcode;
          cmd_q   <= command;
          state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          dropped_q <= cmd_recv_rx;
          case (op_q)
            OP_RESET: begin reset_q <= 1'b1; state_q <= ST_IDLE; end
            OP_ARM:   begin arm_q <= 1'b1; armed_q <= 1'b1; state_q <= ST_ARMED; end
            OP_ID, OP_META: begin
              id_pending_q <= (op_q == OP_ID);
              mux_q        <= 1'b1;
              state_q      <= ST_ID_WAIT;
            end
            default: state_q <= ST_IDLE;
          endcase
        end
        ST_ID_WAIT: begin
          dropped_q <= cmd_recv_rx;
          if (!transmit_busy) begin
            if (id_pending_q) begin
              send_id_q <= 1'b1;
              state_q   <= ST_META_WAIT;
            end else begin
              state_q <= ST_META_START;
            end
          end
        end
        // begin_meta_transmit is high in the first META_WAIT cycle, where finish is already watched.
        ST_META_START: begin
          dropped_q    <= cmd_recv_rx;
          begin_meta_q <= 1'b1;
          state_q      <= ST_META_WAIT;
        end
        ST_META_WAIT: begin
          dropped_q <= cmd_recv_rx;
          if (meta_transmit_finish) begin
            mux_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_ARMED, ST_RUNNING: begin
          if (abort) begin
            reset_q <= 1'b1;
            armed_q <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            if (state_q == ST_ARMED && run) begin
              state_q <= ST_RUNNING;
            end else if (state_q == ST_RUNNING && capture_done) begin
              armed_q <= 1'b0;
              state_q <= ST_IDLE;
            end
            if (cmd_recv_rx) begin
              op_q  <= opcode;
              cmd_q <= command;
              if (is_lifecycle(opcode)) dropped_q <= 1'b1;
              else                      live_pend_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign reset               = reset_q;
  assign arm                 = arm_q;
  assign send_id             = send_id_q;
  assign begin_meta_transmit = begin_meta_q;
  assign data_meta_mux       = mux_q;
  assign armed               = armed_q;
  assign cmd_dropped         = dropped_q;

  sump_cfg_regs #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .NUM_STAGES  (NUM_STAGES)
  ) u_regs (
    .clk_i         (clock),
    .rst_ni        (ext_reset_n),
    .wr_en_i       (wr_en),
    .sel_i         (sel),
    .stage_i       (op_q[3:2]),
    .data_i        (cmd_q),
    .divider_o     (divider),
    .read_count_o  (read_count),
    .delay_count_o (delay_count),
    .flags_o       (flags),
    .trig_mask_o   (trig_mask),
    .trig_value_o  (trig_value),
    .trig_config_o (trig_config),
    .rise_pattern_o(risePattern),
    .fall_pattern_o(fallPattern)
  );

endmodule

// File: tb/tb_sump_controller.sv
// Directed + randomized bench for sump_controller; a 4-stage and a 2-stage instance
// share stimulus and are compared against an opcode-level reference model.
module tb_sump_controller;
  localparam int SW = 8;
  localparam logic [6:0] RST = 7'h40, ARM = 7'h20, SID = 7'h10, BMT = 7'h08,
                         MUX = 7'h04, ARMD = 7'h02, DRP = 7'h01, NONE = 7'h00;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic ext_reset_n, cmd_recv_rx, run, capture_done, transmit_busy, meta_transmit_finish;
  logic [7:0]  opcode;
  logic [31:0] command;

  logic reset, arm, send_id, begin_meta_transmit, data_meta_mux, armed, cmd_dropped;
  logic [23:0] divider;
  logic [15:0] read_count, delay_count;
  logic [31:0] flags;
  logic [4*SW-1:0] trig_mask, trig_value;
  logic [127:0] trig_config;
  logic [SW-1:0] rise_p, fall_p;

  logic n2_reset, n2_arm, n2_send_id, n2_bmt, n2_mux, n2_armed, n2_dropped;
  logic [23:0] n2_divider;
  logic [15:0] n2_read_count, n2_delay_count;
  logic [31:0] n2_flags;
  logic [2*SW-1:0] n2_trig_mask, n2_trig_value;
  logic [63:0] n2_trig_config;
  logic [SW-1:0] n2_rise, n2_fall;

  sump_controller #(.SAMPLE_WIDTH(SW), .NUM_STAGES(4)) u1 (
    .clock(clock), .ext_reset_n(ext_reset_n), .opcode(opcode), .command(command),
    .cmd_recv_rx(cmd_recv_rx), .run(run), .capture_done(capture_done),
    .transmit_busy(transmit_busy), .meta_transmit_finish(meta_transmit_finish),
    .reset(reset), .arm(arm), .send_id(send_id), .begin_meta_transmit(begin_meta_transmit),
    .data_meta_mux(data_meta_mux), .armed(armed), .cmd_dropped(cmd_dropped),
    .divider(divider), .read_count(read_count), .delay_count(delay_count), .flags(flags),
    .trig_mask(trig_mask), .trig_value(trig_value), .trig_config(trig_config),
    .risePattern(rise_p), .fallPattern(fall_p));

  sump_controller #(.SAMPLE_WIDTH(SW), .NUM_STAGES(2)) u2 (
    .clock(clock), .ext_reset_n(ext_reset_n), .opcode(opcode), .command(command),
    .cmd_recv_rx(cmd_recv_rx), .run(run), .capture_done(capture_done),
    .transmit_busy(transmit_busy), .meta_transmit_finish(meta_transmit_finish),
    .reset(n2_reset), .arm(n2_arm), .send_id(n2_send_id), .begin_meta_transmit(n2_bmt),
    .data_meta_mux(n2_mux), .armed(n2_armed), .cmd_dropped(n2_dropped),
    .divider(n2_divider), .read_count(n2_read_count), .delay_count(n2_delay_count), .flags(n2_flags),
    .trig_mask(n2_trig_mask), .trig_value(n2_trig_value), .trig_config(n2_trig_config),
    .risePattern(n2_rise), .fallPattern(n2_fall));

  int checks = 0;
  int errors = 0;

  // Reference model: register contents as the opcode rules define them.
  logic [23:0] m_div;
  logic [15:0] m_rc, m_dc;
  logic [31:0] m_flags;
  logic [7:0]  m_mask[4], m_value[4], m2_mask[2], m2_value[2], m_rise, m_fall;
  logic [31:0] m_cfg[4], m2_cfg[2];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_div = '0; m_rc = '0; m_dc = '0; m_flags = '0; m_rise = '0; m_fall = '0;
    for (int i = 0; i < 4; i++) begin m_mask[i] = '0; m_value[i] = '0; m_cfg[i] = '0; end
    for (int i = 0; i < 2; i++) begin m2_mask[i] = '0; m2_value[i] = '0; m2_cfg[i] = '0; end
  endtask

  task automatic model_write(input logic [7:0] op, input logic [31:0] c);
    int d, s, k;
    d = int'(op) - 32'hC0;
    if (op == 8'h80) m_div = c[23:0];
    else if (op == 8'h81) begin m_rc = c[15:0]; m_dc = c[31:16]; end
    else if (op == 8'h82) m_flags = c;
    else if (op == 8'hD0) m_rise = c[7:0];
    else if (op == 8'hD1) m_fall = c[7:0];
    else if (d >= 0 && d < 16) begin
      s = d / 4;
      k = d % 4;
      if (k == 0) m_mask[s] = c[7:0];
      if (k == 1) m_value[s] = c[7:0];
      if (k == 2) m_cfg[s] = c;
      if (s < 2 && k == 0) m2_mask[s] = c[7:0];
      if (s < 2 && k == 1) m2_value[s] = c[7:0];
      if (s < 2 && k == 2) m2_cfg[s] = c;
    end
  endtask

  task automatic check_ctl(input string tag, input logic [6:0] exp);
    check(tag, 128'({reset, arm, send_id, begin_meta_transmit, data_meta_mux, armed, cmd_dropped}), 128'(exp));
    check({tag, ".n2"}, 128'({n2_reset, n2_arm, n2_send_id, n2_bmt, n2_mux, n2_armed, n2_dropped}), 128'(exp));
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".div"}, 128'(divider), 128'(m_div));
    check({tag, ".cnt"}, 128'({delay_count, read_count}), 128'({m_dc, m_rc}));
    check({tag, ".flags"}, 128'(flags), 128'(m_flags));
    check({tag, ".mask"}, 128'(trig_mask), 128'({m_mask[3], m_mask[2], m_mask[1], m_mask[0]}));
    check({tag, ".value"}, 128'(trig_value), 128'({m_value[3], m_value[2], m_value[1], m_value[0]}));
    check({tag, ".cfg"}, trig_config, {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]});
    check({tag, ".edge"}, 128'({rise_p, fall_p}), 128'({m_rise, m_fall}));
    check({tag, ".n2trig"}, 128'({n2_trig_mask, n2_trig_value}),
          128'({m2_mask[1], m2_mask[0], m2_value[1], m2_value[0]}));
    check({tag, ".n2cfg"}, 128'(n2_trig_config), 128'({m2_cfg[1], m2_cfg[0]}));
    check({tag, ".n2misc"}, 128'({n2_divider, n2_read_count, n2_delay_count, n2_flags, n2_rise, n2_fall}),
          128'({m_div, m_rc, m_dc, m_flags, m_rise, m_fall}));
  endtask

  task automatic send(input logic [7:0] op, input logic [31:0] c);
    opcode = op;
    command = c;
    cmd_recv_rx = 1'b1;
    tick();
    cmd_recv_rx = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [7:0] op, input logic [31:0] c);
    send(op, c);
    check_ctl({tag, ".c1"}, NONE);
    tick();
    model_write(op, c);
    check_ctl({tag, ".c2"}, NONE);
    check_regs(tag);
  endtask

  function automatic logic [7:0] rand_write_op();
    logic [7:0] op;
    case ($urandom_range(0, 5))
      0: op = 8'h80;
      1: op = 8'h81;
      2: op = 8'h82;
      3: op = 8'hC0 + 8'($urandom_range(0, 15));
      4: op = ($urandom_range(0, 1) != 0) ? 8'hD1 : 8'hD0;
      default: op = 8'($urandom_range(0, 255));
    endcase
    if (op == 8'h00 || op == 8'h01 || op == 8'h02 || op == 8'h04) op = 8'h13;
    return op;
  endfunction

  initial begin
    logic [31:0] c;
    ext_reset_n = 1'b0; cmd_recv_rx = 1'b0; run = 1'b0; capture_done = 1'b0;
    transmit_busy = 1'b0; meta_transmit_finish = 1'b0; opcode = '0; command = '0;
    model_reset();
    tick(); tick();
    check_ctl("rst.ctl", NONE);
    check_regs("rst");
    ext_reset_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) do_write("rnd", rand_write_op(), $urandom);
    do_write("div", 8'h80, 32'h0012_3456);
    check("div.exact", 128'(divider), 128'(24'h123456));
    do_write("c5", 8'hC5, 32'h0000_00A5);
    check("c5.byte", 128'(trig_value[15:8]), 128'(8'hA5));
    do_write("cd", 8'hCD, 32'h0000_005A);
    do_write("u11", 8'h11, $urandom);
    do_write("u13", 8'h13, $urandom);

    // ID reply with the transmitter busy for five cycles
    transmit_busy = 1'b1;
    send(8'h02, 32'h0);
    check_ctl("id.c1", NONE);
    tick();
    for (int i = 0; i < 5; i++) begin check_ctl("id.busy", MUX); tick(); end
    transmit_busy = 1'b0;
    tick();
    check_ctl("id.send", SID | MUX);
    tick();
    check_ctl("id.wait", MUX);
    meta_transmit_finish = 1'b1;
    tick();
    meta_transmit_finish = 1'b0;
    check_ctl("id.done", NONE);

    // Metadata reply, finish on the begin_meta_transmit cycle
    send(8'h04, 32'h0);
    check_ctl("meta.c1", NONE);
    tick();
    check_ctl("meta.idw", MUX);
    tick();
    check_ctl("meta.start", MUX);
    tick();
    check_ctl("meta.begin", BMT | MUX);
    meta_transmit_finish = 1'b1;
    tick();
    meta_transmit_finish = 1'b0;
    check_ctl("meta.done", NONE);

    // Command dropped in META_WAIT, then reset mid-reply
    send(8'h02, 32'h0);
    tick(); tick();
    check_ctl("drop.sid", SID | MUX);
    tick();
    send(8'h80, 32'hDEAD_BEEF);
    check_ctl("drop.pulse", DRP | MUX);
    tick();
    check_ctl("drop.after", MUX);
    check_regs("drop");
    ext_reset_n = 1'b0;
    tick();
    model_reset();
    check_ctl("mrst.ctl", NONE);
    check_regs("mrst");
    tick();
    ext_reset_n = 1'b1;
    meta_transmit_finish = 1'b1;
    tick();
    meta_transmit_finish = 1'b0;
    check_ctl("mrst.fin", NONE);
    do_write("post", 8'h82, $urandom);

    // Capture lifecycle
    send(8'h01, 32'h0);
    check_ctl("cap.c1", NONE);
    tick();
    check_ctl("cap.arm", ARM | ARMD);
    tick();
    check_ctl("cap.armed", ARMD);
    capture_done = 1'b1; tick(); capture_done = 1'b0;
    check_ctl("cap.ignored", ARMD);
    run = 1'b1; tick(); run = 1'b0;
    check_ctl("cap.run", ARMD);
    capture_done = 1'b1; tick(); capture_done = 1'b0;
    check_ctl("cap.done", NONE);

    // run and capture_done together: capture_done is lost
    send(8'h01, 32'h0);
    tick(); tick();
    run = 1'b1; capture_done = 1'b1; tick(); run = 1'b0; capture_done = 1'b0;
    check_ctl("both.run", ARMD);
    tick();
    check_ctl("both.hold", ARMD);
    capture_done = 1'b1; tick(); capture_done = 1'b0;
    check_ctl("both.done", NONE);

    // Abort while ARMED
    send(8'h01, 32'h0);
    tick(); tick();
    send(8'h00, 32'h0);
    check_ctl("abort.c1", ARMD);
    tick();
    check_ctl("abort.rst", RST);
    tick();
    check_ctl("abort.idle", NONE);

    // RUNNING: lifecycle opcode dropped, register write applied
    send(8'h01, 32'h0);
    tick(); tick();
    run = 1'b1; tick(); run = 1'b0;
    send(8'h04, 32'h0);
    check_ctl("rundrop.pulse", DRP | ARMD);
    tick();
    check_ctl("rundrop.after", ARMD);
    c = $urandom;
    send(8'h81, c);
    check_ctl("live.c1", ARMD);
    tick();
    model_write(8'h81, c);
    check_ctl("live.c2", ARMD);
    check_regs("live");
    capture_done = 1'b1; tick(); capture_done = 1'b0;
    check_ctl("live.done", NONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
